// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding, sizing helper and default watchdog
// limit for uart_tx_arbiter and its round-robin picker.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // About two 10-bit frames at 9600 baud on a 12 MHz clock.
    localparam int DEFAULT_TIMEOUT_CYCLES = 25000;

    // Ceiling log2; returns 0 for inputs of 1 or less.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin winner search. The slot right
// after the last grant has the highest priority, the last grant the lowest.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-to-nearest from last so the nearest set bit is written last and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it holding state (no latch).
        winner    = '0;
        cand      = '0;
        any_valid = |req;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one Uart8 transmitter among NUM_REQ byte producers.
// Grants round-robin, drives txStart/txByte against txBusy/txDone and returns
// a per-requester completion pulse. Optional frame watchdog is enabled by
// defining UART_TX_ARBITER_TIMEOUT_EN; without it reqErr is tied low.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDX_W         = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 en,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   reqDone,
    output logic [NUM_REQ-1:0]   reqErr,
    output logic                 busy,
    output logic [IDX_W-1:0]     owner,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txByte,
    input  logic                 txBusy,
    input  logic                 txDone
);

    localparam int               GAP_W       = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_t       AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [GAP_W-1:0] gap_cnt;
    logic             timeout_hit;
    logic             frame_end;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (reqValid),
        .last      (last_grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign busy      = (state != IDLE);
    assign frame_end = timeout_hit || (state == SEND && txDone);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int              WD_W    = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0]    wd_cnt;
    logic [NUM_REQ-1:0] err_q;

    assign timeout_hit = (state == START || state == SEND) && (wd_cnt == WD_LAST);
    assign reqErr      = err_q;

    // Watchdog: counts clocks spent in START/SEND, restarting on every state change.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wd_cnt <= '0;
        end else if (timeout_hit || (state != START && state != SEND) ||
                     (state == START && txBusy) || (state == SEND && txDone)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Error flag: pulses together with reqDone when the watchdog aborts a frame.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_q <= '0;
        end else begin
            err_q <= '0;
            if (timeout_hit) begin
                err_q[owner] <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign reqErr         = '0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Arbitration FSM: every client-side and Uart8-side output is registered here.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            txByte     <= '0;
            txStart    <= 1'b0;
            txEn       <= 1'b0;
            reqReady   <= '0;
            reqDone    <= '0;
            gap_cnt    <= '0;
        end else begin
            // NOTE: state uses non-blocking assignment so the later per-bit writes below override these pulse defaults without ordering races.
            txEn     <= en;
            reqReady <= '0;
            reqDone  <= '0;
            case (state)
                IDLE: begin
                    if (en && any_valid) begin
                        txByte           <= reqData[{winner, 3'b000} +: 8];
                        owner            <= winner;
                        reqReady[winner] <= 1'b1;
                        txStart          <= 1'b1;
                        state            <= START;
                    end
                end
                START, SEND: begin
                    if (frame_end) begin
                        txStart        <= 1'b0;
                        reqDone[owner] <= 1'b1;
                        last_grant     <= owner;
                        txByte         <= '0;
                        gap_cnt        <= '0;
                        state          <= AFTER_FRAME;
                    end else if (state == START && txBusy) begin
                        txStart <= 1'b0;
                        state   <= SEND;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmitter of one Uart8 instance among NUM_REQ byte-producing requesters.
- Each requester offers one byte on a valid/ready handshake. The block grants requesters round-robin, sequences the Uart8 tx interface (txEn/txStart/txByte against txBusy/txDone), and returns a per-requester completion pulse.
- Sits between client logic and Uart8 on the board clock (12 MHz Alhambra).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clocks inserted after each frame before the next grant (0..65535).
- TIMEOUT_CYCLES, 25000, watchdog limit in clocks per frame; used only with the optional feature. Default is about 2 frames at 9600 baud / 12 MHz.

Ports:
- clk  in  1  system clock.
- rstN  in  1  asynchronous reset, active low.
- en  in  1  enable; when low, no new grants are issued.
- reqValid  in  NUM_REQ  requester i has a byte pending; held until its reqReady.
- reqData  in  8*NUM_REQ  byte of requester i is at [8i+7:8i].
- reqReady  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- reqDone  out  NUM_REQ  one-cycle pulse: the frame for requester i has finished.
- reqErr  out  NUM_REQ  one-cycle pulse together with reqDone: frame aborted. Constant 0 without the optional feature.
- busy  out  1  high whenever the FSM is not in IDLE.
- owner  out  clog2(NUM_REQ)  index of the current or last granted requester.
- txEn  out  1  to Uart8 txEn; registered copy of en.
- txStart  out  1  to Uart8 txStart.
- txByte  out  8  to Uart8 in.
- txBusy  in  1  from Uart8.
- txDone  in  1  from Uart8.

Behaviour:
- Reset (rstN low, asynchronous):
  - State is IDLE; lastGrant = NUM_REQ-1.
  - All outputs are 0, including txEn, txByte and owner.
  - Gap and watchdog counters are cleared.
  - Reset mid-frame abandons the frame silently: no reqDone pulse. txStart drops immediately.
- States: IDLE, START, SEND, GAP.
- IDLE:
  - When en=1 and any reqValid bit is set, pick the winner: first set bit searching from lastGrant+1 upward, wrapping modulo NUM_REQ.
  - On the next edge:
    - Latch reqData of the winner into txByte and set owner.
    - Pulse reqReady[owner] for exactly one cycle.
    - Set txStart=1 and go to START.
  - Latency from reqValid sampled high to reqReady high is 1 clock.
- START:
  - Hold txStart=1 with txByte stable until txBusy is sampled 1.
  - Then clear txStart and go to SEND.
  - txDone while in START is ignored.
- SEND:
  - On a txDone pulse: pulse reqDone[owner], set lastGrant=owner, clear txByte to 0.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE. No grants are issued during GAP.
- Fairness:
  - A requester that has just been served has the lowest priority in the next arbitration.
  - With all NUM_REQ requesters valid, the grant order is 0,1,2,...,NUM_REQ-1,0.
- en low:
  - Blocks grants in IDLE only. A frame already in flight completes normally.
  - txEn follows en with one register stage.
- Simultaneous events:
  - reqValid may deassert in the same cycle as another requester's grant; only the winner's data is latched.
  - Completion (reqDone) and the next grant never occur in the same cycle; the earliest next reqReady is 1 clock after reqDone when GAP_CYCLES=0.
- txDone in IDLE or GAP is ignored.
- Exactly one bit of reqReady, reqDone and reqErr is ever set at a time.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in START and SEND, cleared on every state entry.
  - If it reaches TIMEOUT_CYCLES: clear txStart, pulse reqDone[owner] and reqErr[owner] together, set lastGrant=owner, then go to GAP or IDLE using the normal rule.
- Undefined:
  - No counter is built; reqErr is tied to 0. The FSM waits indefinitely for txBusy/txDone.

Decomposition:
- Package uart_arb_pkg:
  - state encoding constants IDLE=2'd0, START=2'd1, SEND=2'd2, GAP=2'd3;
  - clog2 helper function;
  - default TIMEOUT_CYCLES constant.
- Sub-module uart_rr_pick (combinational):
  - inputs: request vector, lastGrant;
  - outputs: winner index and anyValid.
  - Instantiated once.

Test Plan:
- Single request: reqValid=4'b0001, reqData[7:0]=8'hB5, with Uart8 at CLOCK_RATE=12000000 and 9600 baud -> reqReady[0] 1 clock later; txByte=8'hB5; one reqDone[0] pulse at txDone, about 1.04 ms later; line bits observed LSB first as 1,0,1,0,1,1,0,1.
- All four valid, data 8'h11/22/33/44 held -> grants in order 0,1,2,3, bytes sent in that order, one reqDone per requester, never overlapping.
- Requesters 1 and 3 continuously valid, GAP_CYCLES=100 -> grants alternate 1,3,1,3; exactly 100 clocks of IDLE txStart=0 between each reqDone and the next reqReady.
- en=0 with reqValid=4'b0100 -> no reqReady for 1000 clocks. Drop en to 0 while in SEND -> the frame still completes with reqDone[2].
- rstN pulsed low during SEND -> all outputs 0 asynchronously, no reqDone; after release, the first grant goes to the lowest-index valid requester.
- With UART_TX_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=500, txBusy held 0 -> reqDone[owner] and reqErr[owner] pulse 500 clocks after reqReady, txStart clears, and the next requester is granted.
